// File: rtl/sized_data_mem_pkg.sv
// Shared encodings for the sized data memory: access sizes, fault codes, clear FSM states.
`timescale 1ns/1ps
package sized_data_mem_pkg;

   // funct3 access-size encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Sticky fault codes
   localparam logic [1:0] FLT_NONE     = 2'b00;
   localparam logic [1:0] FLT_MISALIGN = 2'b01;
   localparam logic [1:0] FLT_RANGE    = 2'b10;
   localparam logic [1:0] FLT_ILLEGAL  = 2'b11;

   // Post-reset clear sequencer
   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   // True for the five funct3 codes the memory understands
   function automatic logic f3_legal(input logic [2:0] f3);
      logic ok;
      case (f3)
         F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
         default:                        ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/sized_data_mem_lane_fmt.sv
// Combinational lane formatter: store byte-enables/replication and load lane select with extension.
`timescale 1ns/1ps
module mem_lane_fmt
   import sized_data_mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  byte_en,
   output logic [31:0] store_word,
   output logic [31:0] load_data
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Store direction: replicate right-aligned data across lanes and pick enables
   always_comb begin
      byte_en    = '0;
      store_word = store_data;
      case (funct3)
         F3_B, F3_BU: begin
            byte_en    = 4'b0001 << lane;
            store_word = {4{store_data[7:0]}};
         end
         F3_H, F3_HU: begin
            byte_en    = lane[1] ? 4'b1100 : 4'b0011;
            store_word = {2{store_data[15:0]}};
         end
         F3_W: begin
            byte_en    = '1;
            store_word = store_data;
         end
         default: ;
      endcase
   end

   // Load direction: select the addressed lane(s) and sign/zero extend
   always_comb begin
      sel_byte  = load_word[7:0];
      sel_half  = lane[1] ? load_word[31:16] : load_word[15:0];
      load_data = '0;
      case (lane)
         2'd0: sel_byte = load_word[7:0];
         2'd1: sel_byte = load_word[15:8];
         2'd2: sel_byte = load_word[23:16];
         2'd3: sel_byte = load_word[31:24];
         default: ;
      endcase
      case (funct3)
         F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
         F3_BU:   load_data = {24'd0, sel_byte};
         F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
         F3_HU:   load_data = {16'd0, sel_half};
         F3_W:    load_data = load_word;
         default: load_data = '0;
      endcase
   end

endmodule

// File: rtl/sized_data_mem.sv
// Sized data memory with byte/half/word access, registered writeback, fault detection and post-reset clear.
`timescale 1ns/1ps
module sized_data_mem
   import sized_data_mem_pkg::*;
#(
   parameter  int unsigned DEPTH_WORDS = 256,
   parameter  int unsigned ADDR_W      = 32,
   localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic              sysclk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] alu_result,
   input  logic [2:0]        funct3,
   input  logic [31:0]       write_data,
   input  logic              mem_write,
   input  logic              mem_read,
   input  logic              mem_to_reg,
   input  logic              fault_clr,
   output logic [31:0]       data_out,
   output logic              rd_valid,
   output logic              ready,
   output logic              fault,
   output logic [1:0]        fault_code
);

   state_t            state;
   logic [IDX_W-1:0]  clear_idx;
   logic [31:0]       mem [DEPTH_WORDS];

   logic [IDX_W-1:0]  word_idx;
   logic [1:0]        lane;
   logic              out_of_range;
   logic              misaligned;
   logic [1:0]        req_code;
   logic              req_active;
   logic              req_bad;
   logic              do_store;
   logic [31:0]       read_word;
   logic [3:0]        byte_en;
   logic [31:0]       store_word;
   logic [31:0]       load_data;

   assign ready        = (state == RUN);
   assign word_idx     = alu_result[IDX_W+1:2];
   assign lane         = alu_result[1:0];
   assign out_of_range = |alu_result[ADDR_W-1:IDX_W+2];
   assign misaligned   = (((funct3 == F3_H) || (funct3 == F3_HU)) && alu_result[0]) ||
                         ((funct3 == F3_W) && (alu_result[1:0] != 2'b00));
   assign req_active   = ready && (mem_read || mem_write);
   assign req_bad      = req_active && (req_code != FLT_NONE);
   assign do_store     = ready && mem_write && (req_code == FLT_NONE);
   assign read_word    = mem[word_idx];

   // Fault classification, highest priority first
   always_comb begin
      req_code = FLT_NONE;
      if (!f3_legal(funct3))
         req_code = FLT_ILLEGAL;
      else if (out_of_range)
         req_code = FLT_RANGE;
      else if (misaligned)
         req_code = FLT_MISALIGN;
   end

   mem_lane_fmt u_fmt (
      .funct3     (funct3),
      .lane       (lane),
      .store_data (write_data),
      .load_word  (read_word),
      .byte_en    (byte_en),
      .store_word (store_word),
      .load_data  (load_data)
   );

   // Clear sequencer: one word zeroed per cycle, then RUN until the next reset
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= CLEAR;
         clear_idx <= '0;
      end else if (state == CLEAR) begin
         clear_idx <= clear_idx + 1'b1;
         if (clear_idx == IDX_W'(DEPTH_WORDS - 1))
            state <= RUN;
      end
   end

   // Array write port: clear writes during CLEAR, byte-enabled stores in RUN
   always_ff @(posedge sysclk) begin
      if (state == CLEAR) begin
         mem[clear_idx] <= '0;
      end else if (do_store) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (byte_en[i])
               mem[word_idx][8*i +: 8] <= store_word[8*i +: 8];
         end
      end
   end

   // Writeback register: passthrough, formatted load (zero on fault), or hold
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         data_out <= '0;
         rd_valid <= 1'b0;
      end else if (state != RUN) begin
         data_out <= '0;
         rd_valid <= 1'b0;
      end else if (!mem_to_reg) begin
         data_out <= 32'(alu_result);
         rd_valid <= 1'b0;
      end else if (mem_read) begin
         data_out <= (req_code == FLT_NONE) ? load_data : '0;
         rd_valid <= 1'b1;
      end else begin
         rd_valid <= 1'b0;
      end
   end

   // Sticky fault: first code wins unless cleared in the same cycle
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         fault      <= 1'b0;
         fault_code <= FLT_NONE;
      end else if (req_bad) begin
         fault <= 1'b1;
         if (!fault || fault_clr)
            fault_code <= req_code;
      end else if (fault_clr) begin
         fault      <= 1'b0;
         fault_code <= FLT_NONE;
      end
   end

endmodule

// File: tb/tb_sized_data_mem.sv
// Randomized and directed self-checking bench for sized_data_mem against a byte-array reference model.
`timescale 1ns/1ps
module tb_sized_data_mem;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned NBYTES = DEPTH * 4;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   logic        sysclk = 1'b0;
   logic        rst_n  = 1'b1;
   logic [31:0] alu_result = '0;
   logic [2:0]  funct3     = '0;
   logic [31:0] write_data = '0;
   logic        mem_write  = 1'b0;
   logic        mem_read   = 1'b0;
   logic        mem_to_reg = 1'b1;
   logic        fault_clr  = 1'b0;
   logic [31:0] data_out;
   logic        rd_valid;
   logic        ready;
   logic        fault;
   logic [1:0]  fault_code;

   int tests  = 0;
   int failed = 0;

   // Reference model state
   logic [7:0]  mdl_mem [NBYTES];
   logic [31:0] exp_dout;
   logic        exp_valid;
   logic        exp_fault;
   logic [1:0]  exp_code;

   always #5 sysclk = ~sysclk;

   sized_data_mem #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
      .sysclk     (sysclk),
      .rst_n      (rst_n),
      .alu_result (alu_result),
      .funct3     (funct3),
      .write_data (write_data),
      .mem_write  (mem_write),
      .mem_read   (mem_read),
      .mem_to_reg (mem_to_reg),
      .fault_clr  (fault_clr),
      .data_out   (data_out),
      .rd_valid   (rd_valid),
      .ready      (ready),
      .fault      (fault),
      .fault_code (fault_code)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int unsigned op_size(input logic [2:0] f3);
      case (f3)
         LB, LBU: return 1;
         LH, LHU: return 2;
         LW:      return 4;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NBYTES; i++) mdl_mem[i] = 8'h00;
      exp_dout  = '0;
      exp_valid = 1'b0;
      exp_fault = 1'b0;
      exp_code  = 2'b00;
   endtask

   // One request cycle: drive, predict from the model, clock, compare
   task automatic do_op(input logic rd, input logic wr, input logic m2r, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd, input logic clr);
      int unsigned sz;
      logic [1:0]  code;
      logic [31:0] val;
      mem_read   = rd;
      mem_write  = wr;
      mem_to_reg = m2r;
      alu_result = addr;
      funct3     = f3;
      write_data = wd;
      fault_clr  = clr;

      sz = op_size(f3);
      if (sz == 0)                code = 2'b11;
      else if (addr >= NBYTES)    code = 2'b10;
      else if (addr % sz != 0)    code = 2'b01;
      else                        code = 2'b00;

      val = '0;
      if (code == 2'b00) begin
         for (int i = 0; i < int'(sz); i++) val[8*i +: 8] = mdl_mem[addr + i];
         if (f3 == LB && val[7])  val = val | 32'hFFFF_FF00;
         if (f3 == LH && val[15]) val = val | 32'hFFFF_0000;
      end

      if (!m2r) begin
         exp_dout  = addr;
         exp_valid = 1'b0;
      end else if (rd) begin
         exp_dout  = val;
         exp_valid = 1'b1;
      end else begin
         exp_valid = 1'b0;
      end

      if (wr && code == 2'b00)
         for (int i = 0; i < int'(sz); i++) mdl_mem[addr + i] = wd[8*i +: 8];

      if ((rd || wr) && code != 2'b00) begin
         if (!exp_fault || clr) exp_code = code;
         exp_fault = 1'b1;
      end else if (clr) begin
         exp_fault = 1'b0;
         exp_code  = 2'b00;
      end

      @(posedge sysclk);
      #1;
      check("data_out",   data_out,   exp_dout);
      check("rd_valid",   rd_valid,   exp_valid);
      check("fault",      fault,      exp_fault);
      check("fault_code", fault_code, exp_code);
      check("ready",      ready,      1'b1);
   endtask

   task automatic idle(input logic clr);
      do_op(1'b0, 1'b0, 1'b1, 32'h0, LW, 32'h0, clr);
   endtask

   // Release reset and count edges until ready rises
   task automatic release_and_count();
      int n;
      n = 0;
      @(negedge sysclk);
      rst_n = 1'b1;
      while (!ready && n < 100) begin
         @(posedge sysclk);
         #1;
         n++;
      end
      check("clear_cycles", n, DEPTH);
      model_reset();
   endtask

   initial begin
      logic [31:0] a;
      logic [2:0]  f;
      logic [2:0]  legal [5];
      legal[0] = LB; legal[1] = LH; legal[2] = LW; legal[3] = LBU; legal[4] = LHU;

      #1 rst_n = 1'b0;
      #1;
      check("rst_data_out", data_out,   32'h0);
      check("rst_rd_valid", rd_valid,   1'b0);
      check("rst_ready",    ready,      1'b0);
      check("rst_fault",    fault,      1'b0);
      check("rst_code",     fault_code, 2'b00);
      #20;
      release_and_count();

      // Cleared array reads zero with a one-cycle valid pulse
      do_op(1, 0, 1, 32'h3C, LW, 0, 0);
      check("lw3c_data", data_out, 32'h0);
      check("lw3c_valid", rd_valid, 1'b1);
      idle(0);

      // Sized loads with sign/zero extension
      do_op(0, 1, 1, 32'h0, LW, 32'h80FF_7F01, 0);
      do_op(1, 0, 1, 32'h3, LB, 0, 0);
      check("lb3", data_out, 32'hFFFF_FF80);
      do_op(1, 0, 1, 32'h3, LBU, 0, 0);
      check("lbu3", data_out, 32'h0000_0080);
      do_op(1, 0, 1, 32'h2, LH, 0, 0);
      check("lh2", data_out, 32'hFFFF_80FF);
      do_op(1, 0, 1, 32'h2, LHU, 0, 0);
      check("lhu2", data_out, 32'h0000_80FF);
      do_op(1, 0, 1, 32'h0, LB, 0, 0);
      check("lb0", data_out, 32'h0000_0001);

      // Byte store leaves neighbouring lanes intact
      do_op(0, 1, 1, 32'h4, LW, 32'h1122_3344, 0);
      do_op(0, 1, 1, 32'h5, LB, 32'h0000_00AA, 0);
      do_op(1, 0, 1, 32'h4, LW, 0, 0);
      check("sb_merge", data_out, 32'h1122_AA44);

      // Misaligned store suppressed, first fault wins, clear then range fault
      do_op(0, 1, 1, 32'h3, LH, 32'h0000_BEEF, 0);
      check("sh3_code", fault_code, 2'b01);
      do_op(1, 0, 1, 32'h0, LW, 0, 0);
      check("sh3_nowrite", data_out, 32'h80FF_7F01);
      do_op(1, 0, 1, 32'h400, LW, 0, 0);
      check("sticky_code", fault_code, 2'b01);
      check("range_load_zero", data_out, 32'h0);
      idle(1);
      do_op(1, 0, 1, 32'h400, LW, 0, 0);
      check("range_code", fault_code, 2'b10);

      // Read-first on a simultaneous load and store
      do_op(0, 1, 1, 32'h0, LW, 32'h6, 0);
      do_op(1, 1, 1, 32'h0, LW, 32'h5, 0);
      check("rmw_old", data_out, 32'h6);
      do_op(1, 0, 1, 32'h0, LW, 0, 0);
      check("rmw_new", data_out, 32'h5);
      idle(1);

      // Random traffic against the model
      for (int k = 0; k < 250; k++) begin
         f = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : legal[$urandom_range(0, 4)];
         if ($urandom_range(0, 9) == 0) a = $urandom;
         else                           a = $urandom_range(0, NBYTES - 1);
         if ($urandom_range(0, 1) == 0 && op_size(f) != 0) a = a & ~(op_size(f) - 1);
         do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
               a, f, $urandom, 1'($urandom_range(0, 7) == 0));
      end

      // Passthrough, then asynchronous reset mid-run and mid-clear
      do_op(0, 1, 1, 32'h8, LW, 32'hDEAD_BEEF, 0);
      do_op(1, 0, 1, 32'h400, LW, 0, 0);
      do_op(0, 0, 0, 32'h1234, LW, 0, 0);
      check("pass_data", data_out, 32'h1234);
      check("pass_valid", rd_valid, 1'b0);
      rst_n = 1'b0;
      #1;
      check("async_data_out", data_out, 32'h0);
      check("async_ready",    ready,    1'b0);
      check("async_fault",    fault,    1'b0);
      check("async_code",     fault_code, 2'b00);
      @(negedge sysclk);
      rst_n = 1'b1;
      repeat (5) @(posedge sysclk);
      #1 rst_n = 1'b0;
      #1;
      check("midclear_ready", ready, 1'b0);
      release_and_count();
      do_op(1, 0, 1, 32'h8, LW, 0, 0);
      check("recleared", data_out, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
